instr_fetch: RTL and testbench

- Producer side of the decoder input for the 8-bit NAND CPU: generates `valid` and the 8-bit `instr` that the decoder consumes.
- Holds the PC and issues single-outstanding reads to instruction memory.
- Presents each fetched byte with its PC to decode/execute.
- Applies PC redirects (jump/branch) with squash, and stops on HLT.

---
 rtl/instr_fetch.sv | 122 ++++++++++++
 tb/tb_instr_fetch.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage for the 8-bit NAND CPU.
// Owns the PC and keeps at most one instruction-memory read in flight.
// Each fetched byte is presented to decode with its PC. Redirects squash
// whatever is in flight, and an accepted HLT parks the stage until reset.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// FETCH    | read outstanding at pc; waiting for imem_rvalid
// DELIVER  | out_instr/out_pc valid and held until accepted or squashed
// DRAIN    | a squashed read is still open; wait it out, then fetch at pc
// HALTED   | HLT accepted; everything ignored until reset
module instr_fetch #(
    parameter int                   PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]  RESET_PC = '0
) (
    input  logic                clk,
    input  logic                n_rst,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_rvalid,
    input  logic [7:0]          imem_rdata,
    output logic                out_valid,
    output logic [7:0]          out_instr,
    output logic [PC_WIDTH-1:0] out_pc,
    input  logic                out_ready,
    input  logic                redirect_valid,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic                halt,
    output logic                halted
);

    typedef enum logic [1:0] {
        ST_FETCH   = 2'd0,
        ST_DELIVER = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_HALTED  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [7:0]          out_instr_q, out_instr_d;
    logic [PC_WIDTH-1:0] out_pc_q, out_pc_d;
    // Address of the squashed read, held on imem_addr while draining so the
    // memory sees a stable request even though pc already moved on.
    logic [PC_WIDTH-1:0] drain_addr_q, drain_addr_d;

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= RESET_PC;
            out_instr_q  <= 8'h00;
            out_pc_q     <= '0;
            drain_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    // Next-state and datapath update; a redirect always takes priority over
    // both an acceptance and a halt in the same cycle.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        drain_addr_d = drain_addr_q;

        case (state_q)
            ST_FETCH: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (!imem_rvalid) begin
                        // Read still open: must wait for its response.
                        state_d      = ST_DRAIN;
                        drain_addr_d = pc_q;
                    end
                end else if (imem_rvalid) begin
                    out_instr_d = imem_rdata;
                    out_pc_d    = pc_q;
                    pc_d        = pc_q + PC_WIDTH'(1);
                    state_d     = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = ST_FETCH;
                end else if (out_ready) begin
                    state_d = halt ? ST_HALTED : ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                end
                if (imem_rvalid) begin
                    state_d = ST_FETCH;
                end
            end
            ST_HALTED: begin
                state_d = ST_HALTED;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
    end

    // Outputs are decoded from registered state only.
    assign imem_req  = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
    assign out_valid = (state_q == ST_DELIVER);
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios plus randomized traffic,
// checked by a scoreboard holding the PC of the next instruction the
// program should deliver.
module tb_instr_fetch;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_rvalid = 1'b0;
    logic [7:0] imem_rdata = 8'h00;
    logic       out_valid;
    logic [7:0] out_instr;
    logic [7:0] out_pc;
    logic       out_ready = 1'b1;
    logic       redirect_valid = 1'b0;
    logic [7:0] redirect_pc = 8'h00;
    logic       halt = 1'b0;
    logic       halted;

    always #5 clk = ~clk;

    instr_fetch #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_ready      (out_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .halted         (halted)
    );

    int         checks = 0;
    int         errors = 0;
    int         accepts = 0;
    int         lat = 1;
    logic [7:0] mem [256];
    logic [7:0] exp_q [$];
    bit         model_halted = 1'b0;
    bit         started = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Program-order model: a redirect means the next delivered instruction is
    // the target; nothing in flight survives it.
    task automatic model_redirect(input logic [7:0] pc);
        if (!model_halted) begin
            exp_q.delete();
            exp_q.push_back(pc);
        end
    endtask

    task automatic reset_dut();
        n_rst = 1'b0;
        redirect_valid = 1'b0;
        halt = 1'b0;
        tick();
        n_rst = 1'b1;
        exp_q.delete();
        exp_q.push_back(8'h00);
        model_halted = 1'b0;
        started = 1'b1;
    endtask

    task automatic redirect(input logic [7:0] pc);
        redirect_valid = 1'b1;
        redirect_pc = pc;
        model_redirect(pc);
        tick();
        redirect_valid = 1'b0;
    endtask

    // Instruction memory: answers in the lat-th cycle of a request and
    // checks that the address does not move while the request is open.
    int         mcnt = 0;
    logic [7:0] hold_addr = 8'h00;
    logic       rst_edge = 1'b0;
    always begin
        @(posedge clk);
        rst_edge = n_rst;
        #2;
        if (!rst_edge) mcnt = 0;
        if (!imem_req) begin
            mcnt = 0;
            imem_rvalid = 1'b0;
        end else begin
            if (mcnt > 0) begin
                checks++;
                if (imem_addr != hold_addr) begin
                    errors++;
                    $display("FAIL addr_stable: got %0h expected %0h", imem_addr, hold_addr);
                end
            end else begin
                hold_addr = imem_addr;
            end
            mcnt++;
            if (mcnt >= lat) begin
                imem_rvalid = 1'b1;
                imem_rdata = mem[imem_addr];
                mcnt = 0;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata = 8'($urandom);
            end
        end
    end

    // Monitor: invariants every cycle; each accepted instruction is popped
    // from the scoreboard and its successor becomes the next expectation.
    always @(negedge clk) begin
        if (started && n_rst) begin
            chk("inv_req_and_valid", {31'd0, imem_req & out_valid}, 32'd0);
            chk("inv_halted_quiet", {31'd0, halted & (imem_req | out_valid)}, 32'd0);
            if (out_valid && out_ready && !redirect_valid) begin
                logic [7:0] e;
                logic [7:0] nx;
                accepts++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got pc %0h expected no delivery", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_pc", {24'd0, out_pc}, {24'd0, e});
                    chk("sb_instr", {24'd0, out_instr}, {24'd0, mem[e]});
                    if (halt) begin
                        model_halted = 1'b1;
                    end else begin
                        nx = e + 8'd1;
                        exp_q.push_back(nx);
                    end
                end
            end
        end
    end

    logic [7:0] t1_instr [3];
    logic [7:0] rp;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h15; mem[1] = 8'h21; mem[2] = 8'h9A; mem[3] = 8'hF0;
        mem[8'h30] = 8'h71; mem[8'hFF] = 8'hC3;
        t1_instr[0] = 8'h15; t1_instr[1] = 8'h21; t1_instr[2] = 8'h9A;
        tick();

        // Reset values and 1-cycle memory streaming.
        lat = 1; out_ready = 1'b1;
        reset_dut();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_instr", {24'd0, out_instr}, 32'h00);
        chk("rst_out_pc", {24'd0, out_pc}, 32'h00);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) begin
                chk("stream_req", {31'd0, imem_req}, 32'd1);
                chk("stream_addr", {24'd0, imem_addr}, i / 2);
                chk("stream_nvalid", {31'd0, out_valid}, 32'd0);
            end else begin
                chk("stream_valid", {31'd0, out_valid}, 32'd1);
                chk("stream_pc", {24'd0, out_pc}, i / 2);
                chk("stream_instr", {24'd0, out_instr}, {24'd0, t1_instr[i/2]});
            end
            tick();
        end

        // Backpressure holds the delivered instruction.
        out_ready = 1'b0;
        reset_dut();
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("hold_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_instr", {24'd0, out_instr}, 32'h15);
            chk("hold_pc", {24'd0, out_pc}, 32'h00);
            chk("hold_noreq", {31'd0, imem_req}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        chk("hold_accept_valid", {31'd0, out_valid}, 32'd1);
        tick();
        chk("hold_next_req", {31'd0, imem_req}, 32'd1);
        chk("hold_next_addr", {24'd0, imem_addr}, 32'h01);
        repeat (2) tick();

        // Redirect during a 3-cycle read: request drains at its address.
        lat = 3;
        reset_dut();
        repeat (3) tick();
        chk("drain_pre_valid", {31'd0, out_valid}, 32'd1);
        redirect(8'h05);
        chk("drain_req5", {24'd0, imem_addr}, 32'h05);
        tick();
        redirect(8'h40);
        chk("drain_hold_req", {31'd0, imem_req}, 32'd1);
        chk("drain_hold_addr", {24'd0, imem_addr}, 32'h05);
        chk("drain_hold_nvalid", {31'd0, out_valid}, 32'd0);
        tick();
        chk("drain_next_req", {31'd0, imem_req}, 32'd1);
        chk("drain_next_addr", {24'd0, imem_addr}, 32'h40);
        repeat (8) tick();

        // Redirect squashes a held instruction even with out_ready=1.
        lat = 1;
        reset_dut();
        redirect(8'h30);
        tick();
        chk("squash_instr", {24'd0, out_instr}, 32'h71);
        chk("squash_pc", {24'd0, out_pc}, 32'h30);
        redirect(8'h10);
        chk("squash_nvalid", {31'd0, out_valid}, 32'd0);
        chk("squash_addr", {24'd0, imem_addr}, 32'h10);
        repeat (4) tick();

        // HLT accepted: stop for good, ignore redirects.
        reset_dut();
        redirect(8'h03);
        tick();
        chk("hlt_instr", {24'd0, out_instr}, 32'hF0);
        halt = 1'b1;
        tick();
        halt = 1'b0;
        chk("hlt_halted", {31'd0, halted}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            redirect_valid = (i % 4 == 0);
            redirect_pc = 8'($urandom);
            chk("hlt_noreq", {31'd0, imem_req}, 32'd0);
            chk("hlt_stay", {31'd0, halted}, 32'd1);
            tick();
        end
        redirect_valid = 1'b0;

        // Redirect beats halt in the same cycle.
        reset_dut();
        redirect(8'h03);
        tick();
        halt = 1'b1;
        redirect(8'h20);
        halt = 1'b0;
        chk("rvh_halted", {31'd0, halted}, 32'd0);
        chk("rvh_req", {31'd0, imem_req}, 32'd1);
        chk("rvh_addr", {24'd0, imem_addr}, 32'h20);
        repeat (4) tick();

        // PC wrap at 8'hFF.
        reset_dut();
        redirect(8'hFF);
        tick();
        chk("wrap_pc", {24'd0, out_pc}, 32'hFF);
        chk("wrap_instr", {24'd0, out_instr}, 32'hC3);
        tick();
        chk("wrap_addr", {24'd0, imem_addr}, 32'h00);
        repeat (4) tick();

        // Reset while draining.
        lat = 4;
        reset_dut();
        redirect(8'h60);
        repeat (3) tick();
        chk("rdrain_fetch_addr", {24'd0, imem_addr}, 32'h60);
        redirect(8'h70);
        chk("rdrain_drain_addr", {24'd0, imem_addr}, 32'h60);
        reset_dut();
        chk("rdrain_req", {31'd0, imem_req}, 32'd1);
        chk("rdrain_addr", {24'd0, imem_addr}, 32'h00);
        chk("rdrain_nvalid", {31'd0, out_valid}, 32'd0);
        repeat (8) tick();

        // Randomized traffic at three memory latencies.
        for (int seg = 0; seg < 3; seg++) begin
            lat = 1 + seg;
            reset_dut();
            for (int c = 0; c < 300; c++) begin
                out_ready = ($urandom % 4) != 0;
                halt = ($urandom % 80) == 0;
                if ($urandom % 8 == 0) begin
                    rp = 8'($urandom);
                    redirect_valid = 1'b1;
                    redirect_pc = rp;
                    model_redirect(rp);
                end else begin
                    redirect_valid = 1'b0;
                end
                tick();
            end
            redirect_valid = 1'b0;
            halt = 1'b0;
            out_ready = 1'b1;
        end

        chk("accepts_seen", {31'd0, accepts > 20}, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
